// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Data wins arbitration; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_q, owner_d;    // 1 = data port owns the access
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              fetch_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      owner_q    <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    fetch_win  = if_req && (!d_req || starve_q == SLIM);
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (fetch_win) begin
          if_gnt   = 1'b1;
          owner_d  = 1'b0;
          rd_d     = 1'b1;
          addr_d   = if_addr;
          starve_d = '0;
          state_d  = ISSUE;
        end else if (d_req) begin
          d_gnt   = 1'b1;
          owner_d = 1'b1;
          rd_d    = !d_we;
          wr_d    = d_we;
          addr_d  = d_addr;
          if (d_we) wdata_d = d_wdata;
          // count only data wins that made a waiting fetch wait longer
          if (!if_req)              starve_d = '0;
          else if (starve_q != SLIM) starve_d = starve_q + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_LAST;
        state_d = wr_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          if (owner_q) d_rdata_d  = mem_rdata;
          else         if_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rvalid = (state_q == RESP) && !owner_q;
  assign d_rvalid  = (state_q == RESP) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts grants, memory commands
// and responses; a negedge monitor pops expectations as the DUT presents outputs.
module tb_mem_port_arbiter;
  localparam int L = 1, L3 = 3, LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic        mem_read, mem_write, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req3, if_gnt3, if_rvalid3, d_req3, d_we3, d_gnt3, d_rvalid3;
  logic        mem_read3, mem_write3, busy3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L3), .STARVE_LIMIT(LIM)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
    .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3));

  // Memories: data appears RD_LATENCY cycles after the read strobe, garbage otherwise.
  logic [31:0] mem [64];
  logic [31:0] rdp [L];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    rdp[0] <= mem_read ? mem[mem_addr[7:2]] : 32'hBADBAD00;
    for (int i = 1; i < L; i++) rdp[i] <= rdp[i-1];
  end
  assign mem_rdata = rdp[L-1];

  logic [31:0] mem3 [64];
  logic [31:0] rdp3 [L3];
  always @(posedge clk) begin
    rdp3[0] <= mem_read3 ? mem3[mem_addr3[7:2]] : 32'hBADBAD03;
    for (int i = 1; i < L3; i++) rdp3[i] <= rdp3[i-1];
  end
  assign mem_rdata3 = rdp3[L3-1];

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t if_q[$], d_q[$];
  logic [31:0] shd [64];
  int next_ok = 0, consec = 0, busy_lo = 0, busy_hi = -1;
  logic [31:0] last_if = 0, last_d = 0, last_addr = 0, last_wdata = 0;
  logic mon_en = 1'b0;

  // Requester slots
  logic        if_pend = 0, d_pend = 0, d_w = 0, rnd = 0, refill_d = 0;
  logic [31:0] if_a = 0, d_a = 0, d_wd = 0;
  int          dlog[$];

  function automatic logic [31:0] raddr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  task automatic model_eval();
    logic elig, eif, ed;
    elig = cyc >= next_ok;
    eif  = elig && if_req && (!d_req || consec == LIM);
    ed   = elig && d_req && !eif;
    chk("if_gnt", if_gnt, eif);
    chk("d_gnt", d_gnt, ed);
    if (eif) begin
      cmd_q.push_back('{cyc + 1, 1'b0, if_addr, 32'h0});
      if_q.push_back('{cyc + 2 + L, shd[if_addr[7:2]]});
      next_ok = cyc + 2 + L; busy_lo = cyc + 1; busy_hi = cyc + 1 + L;
      consec = 0;
    end else if (ed) begin
      cmd_q.push_back('{cyc + 1, d_we, d_addr, d_wdata});
      busy_lo = cyc + 1;
      if (d_we) begin
        shd[d_addr[7:2]] = d_wdata;
        next_ok = cyc + 2; busy_hi = cyc + 1;
      end else begin
        d_q.push_back('{cyc + 2 + L, shd[d_addr[7:2]]});
        next_ok = cyc + 2 + L; busy_hi = cyc + 1 + L;
      end
      consec = if_req ? ((consec < LIM) ? consec + 1 : LIM) : 0;
    end
  endtask

  task automatic cycle();
    if (rnd) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1; if_a = raddr(); end
      else if (if_pend && $urandom_range(0, 15) == 0) if_pend = 0;
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_w = 1'($urandom_range(0, 1)); d_a = raddr(); d_wd = $urandom;
      end else if (d_pend && $urandom_range(0, 15) == 0) d_pend = 0;
    end
    if_req = if_pend; if_addr = if_a;
    d_req = d_pend; d_we = d_w; d_addr = d_a; d_wdata = d_wd;
    @(negedge clk);
    model_eval();
    if (if_gnt) begin if_pend = 0; dlog.push_back(0); end
    if (d_gnt) begin
      d_pend = 0; dlog.push_back(1);
      if (refill_d) begin d_pend = 1; d_w = 1; d_a = raddr(); d_wd = $urandom; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && (if_pend || d_pend); i++) cycle();
    chk("req_timeout", {31'h0, if_pend | d_pend}, 0);
    repeat (L + 3) cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {25'h0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy}, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a command or response.
  always @(negedge clk) begin : mon
    cmd_t c;
    rsp_t r;
    if (mon_en) begin
      chk("rw_exclusive", {31'h0, mem_read & mem_write}, 0);
      if (mem_read || mem_write) begin
        if (cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
        else begin
          c = cmd_q.pop_front();
          chk("cmd_cycle", cyc, c.cyc);
          chk("cmd_we", {31'h0, mem_write}, {31'h0, c.we});
          chk("mem_addr", mem_addr, c.addr);
          last_addr = c.addr;
          if (c.we) begin chk("mem_wdata", mem_wdata, c.wdata); last_wdata = c.wdata; end
          else chk("mem_wdata_hold", mem_wdata, last_wdata);
        end
      end else begin
        chk("mem_addr_hold", mem_addr, last_addr);
        chk("mem_wdata_hold", mem_wdata, last_wdata);
      end
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("unexpected_if_rvalid", 1, 0);
        else begin
          r = if_q.pop_front();
          chk("if_rvalid_cycle", cyc, r.cyc);
          chk("if_rdata", if_rdata, r.data);
          last_if = r.data;
        end
      end else chk("if_rdata_hold", if_rdata, last_if);
      if (d_rvalid) begin
        if (d_q.size() == 0) chk("unexpected_d_rvalid", 1, 0);
        else begin
          r = d_q.pop_front();
          chk("d_rvalid_cycle", cyc, r.cyc);
          chk("d_rdata", d_rdata, r.data);
          last_d = r.data;
        end
      end else chk("d_rdata_hold", d_rdata, last_d);
      chk("busy", {31'h0, busy}, {31'h0, cyc >= busy_lo && cyc <= busy_hi});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_log [6];
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; shd[i] = mem[i]; mem3[i] = $urandom; end
    mem[1] = 32'h00A00093; shd[1] = 32'h00A00093;
    mem[5] = 32'hCAFEBABE; shd[5] = 32'hCAFEBABE;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1; mon_en = 1; next_ok = cyc;

    // Fetch alone
    if_pend = 1; if_a = 32'h4;
    wait_idle(20);
    // Data write then read back; fetch side idle
    d_pend = 1; d_w = 1; d_a = 32'h10; d_wd = 32'hDEADBEEF;
    wait_idle(20);
    d_pend = 1; d_w = 0; d_a = 32'h10;
    wait_idle(20);
    // Simultaneous requests: data first, fetch in the RESP cycle
    if_pend = 1; if_a = 32'h4; d_pend = 1; d_w = 0; d_a = 32'h14;
    wait_idle(20);

    // Starvation with back-to-back data writes
    dlog.delete();
    refill_d = 1; d_pend = 1; d_w = 1; d_a = raddr(); d_wd = $urandom;
    if_pend = 1; if_a = 32'h8;
    for (int i = 0; i < 60 && dlog.size() < 6; i++) cycle();
    refill_d = 0;
    wait_idle(20);
    exp_log = '{1, 1, 1, 1, 0, 1};
    chk("starve_grants", dlog.size() >= 6 ? 32'd6 : 32'(dlog.size()), 6);
    for (int i = 0; i < 6 && i < dlog.size(); i++) chk("starve_order", dlog[i], exp_log[i]);

    // Reset during WAIT of a fetch
    if_pend = 1; if_a = 32'h18;
    for (int i = 0; i < 20 && if_pend; i++) cycle();
    cycle();
    rst_n = 0;
    cmd_q.delete(); if_q.delete(); d_q.delete();
    busy_hi = -1; consec = 0;
    last_if = 0; last_d = 0; last_addr = 0; last_wdata = 0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1; next_ok = cyc;
    repeat (6) cycle();
    if_pend = 1; if_a = 32'h4;
    wait_idle(20);

    // Randomized traffic
    rnd = 1;
    repeat (3000) cycle();
    rnd = 0;
    wait_idle(40);
    chk("queues_drained", 32'(cmd_q.size() + if_q.size() + d_q.size()), 0);

    // RD_LATENCY=3 instance
    if_req3 = 1; if_addr3 = 32'h8;
    @(negedge clk);
    chk("l3_if_gnt", {31'h0, if_gnt3}, 1);
    base = cyc;
    @(posedge clk); #1 if_req3 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("l3_cycle", cyc - base, k);
      chk("l3_busy", {31'h0, busy3}, {31'h0, k <= 4});
      chk("l3_mem_read", {31'h0, mem_read3}, {31'h0, k == 1});
      chk("l3_if_rvalid", {31'h0, if_rvalid3}, {31'h0, k == 5});
      chk("l3_if_gnt_idle", {31'h0, if_gnt3}, 0);
      if (k == 5) chk("l3_if_rdata", if_rdata3, mem3[2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
